// File: rtl/cajero_ledger_arbiter.sv
// Round-robin arbiter sharing one account-balance ledger between N_TERM cashier terminals.
// Optional macro LEDGER_OVF_CHK_EN rejects wrapping deposits and adds the desbordamiento output.
module cajero_ledger_arbiter #(
  parameter int N_TERM = 4,
  parameter int N_ACCT = 8,
  parameter int BAL_W  = 64,
  parameter int AMT_W  = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_TERM-1:0]                   req,
  input  logic [N_TERM-1:0]                   req_type,
  input  logic [N_TERM*$clog2(N_ACCT)-1:0]    req_acct,
  input  logic [N_TERM*AMT_W-1:0]             req_amount,
  output logic [N_TERM-1:0]                   grant,
  output logic [N_TERM-1:0]                   done,
  output logic                                ok,
  output logic                                fondos_insuficientes,
  output logic [BAL_W-1:0]                    resp_balance,
  input  logic                                init_we,
  input  logic [$clog2(N_ACCT)-1:0]           init_acct,
  input  logic [BAL_W-1:0]                    init_balance
`ifdef LEDGER_OVF_CHK_EN
  ,
  output logic                                desbordamiento
`endif
);

  localparam int AW = $clog2(N_ACCT);
  localparam int TW = $clog2(N_TERM);

  typedef enum logic {ARB, EXEC} state_t;

  typedef struct packed {
    logic             wd;
    logic [TW-1:0]    term;
    logic [AW-1:0]    acct;
    logic [AMT_W-1:0] amt;
  } txn_t;

  logic [N_TERM-1:0][AW-1:0]    acct_v;
  logic [N_TERM-1:0][AMT_W-1:0] amt_v;
  assign acct_v = req_acct;
  assign amt_v  = req_amount;

  state_t                    state, state_nxt;
  logic [TW-1:0]             ptr;
  txn_t                      cur;
  logic [N_ACCT-1:0][BAL_W-1:0] bal;

  // Round-robin pick: descending scan so the candidate closest to ptr wins.
  logic [TW:0]       cand;
  logic [TW-1:0]     sel;
  logic [N_TERM-1:0] sel_oh;
  always_comb begin
    sel  = '0;
    cand = '0;
    for (int i = N_TERM-1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (TW+1)'(i);
      if (cand >= (TW+1)'(N_TERM)) cand = cand - (TW+1)'(N_TERM);
      if (req[cand[TW-1:0]]) sel = cand[TW-1:0];
    end
    sel_oh = {{(N_TERM-1){1'b0}}, 1'b1} << sel;
  end

  // Transaction result for the captured request.
  logic [BAL_W-1:0] old_bal, amt_ext, new_bal;
  logic             wr_en, r_ok, r_insuf;
`ifdef LEDGER_OVF_CHK_EN
  logic             r_ovf;
  logic [BAL_W:0]   dep_sum;
`endif
  always_comb begin
    old_bal = bal[cur.acct];
    amt_ext = BAL_W'(cur.amt);
    new_bal = old_bal;
    wr_en   = 1'b0;
    r_ok    = 1'b0;
    r_insuf = 1'b0;
`ifdef LEDGER_OVF_CHK_EN
    r_ovf   = 1'b0;
    dep_sum = {1'b0, old_bal} + {1'b0, amt_ext};
`endif
    if (cur.wd) begin
      if (amt_ext > old_bal) begin
        r_insuf = 1'b1;
      end else begin
        new_bal = old_bal - amt_ext;
        wr_en   = 1'b1;
        r_ok    = 1'b1;
      end
    end else begin
`ifdef LEDGER_OVF_CHK_EN
      if (dep_sum[BAL_W]) begin
        r_ovf = 1'b1;
      end else begin
        new_bal = dep_sum[BAL_W-1:0];
        wr_en   = 1'b1;
        r_ok    = 1'b1;
      end
`else
      new_bal = old_bal + amt_ext;
      wr_en   = 1'b1;
      r_ok    = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:  if (!init_we && (|req)) state_nxt = EXEC;
      EXEC: state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr                  <= '0;
      cur                  <= '0;
      bal                  <= '0;
      grant                <= '0;
      done                 <= '0;
      ok                   <= 1'b0;
      fondos_insuficientes <= 1'b0;
      resp_balance         <= '0;
`ifdef LEDGER_OVF_CHK_EN
      desbordamiento       <= 1'b0;
`endif
    end else begin
      grant <= '0;
      done  <= '0;
      case (state)
        ARB: begin
          // Preload wins over arbitration; requests wait one cycle.
          if (init_we) begin
            bal[init_acct] <= init_balance;
          end else if (|req) begin
            cur   <= '{wd: req_type[sel], term: sel, acct: acct_v[sel], amt: amt_v[sel]};
            grant <= sel_oh;
          end
        end
        EXEC: begin
          if (wr_en) bal[cur.acct] <= new_bal;
          done                 <= {{(N_TERM-1){1'b0}}, 1'b1} << cur.term;
          ok                   <= r_ok;
          fondos_insuficientes <= r_insuf;
          resp_balance         <= new_bal;
`ifdef LEDGER_OVF_CHK_EN
          desbordamiento       <= r_ovf;
`endif
          ptr <= (cur.term == TW'(N_TERM-1)) ? '0 : cur.term + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
